count_frame_packer: RTL
=======================

// Module: count_frame_packer
// PURPOSE
//  Downstream of the gated photon counter. Samples COUNTER on each INTR into a per-gate
//  frame of NUM_BINS 8-bit time bins; the frame closes on CLEAR (end of gate) or when full.
//  Closed frames sit in a 2-slot ping-pong buffer and stream out bin-by-bin over valid/ready
//  to the FNN inference / PS transfer logic. Bins are zero-padded to a fixed-length vector.
// PARAMETERS
//  NUM_BINS   16   bins per frame (2..256); frame length seen by the consumer
//  BIN_W      8    bin width; must equal COUNTER width
// PORTS
//  CLK          in   1      system clock, 100 MHz
//  RST_N        in   1      asynchronous active-low reset
//  INTR         in   1      counter bin-done; rising edge = COUNTER valid this cycle
//  COUNTER      in   BIN_W  current bin count from counter stage
//  CLEAR        in   1      counter gate-end; rising edge closes the open frame
//  CLR_FLAGS    in   1      1-cycle pulse: clears OVERFLOW, SHORT_FRAME, DROP_CNT
//  M_DATA       out  BIN_W  output bin value
//  M_VALID      out  1      M_DATA/M_LAST valid
//  M_LAST       out  1      high with the final bin (index NUM_BINS-1) of a frame
//  M_READY      in   1      consumer accepts when M_VALID & M_READY
//  FRAME_CNT    out  16     frames fully streamed out; wraps 0xFFFF->0
//  DROP_CNT     out  8      frames dropped on overflow; saturates at 0xFF
//  OVERFLOW     out  1      sticky: a frame was dropped
//  SHORT_FRAME  out  1      sticky: a frame closed by CLEAR with < NUM_BINS bins
// BEHAVIOUR
//  Reset: all outputs 0; both slots empty; write FSM W_IDLE; read FSM R_IDLE; edge regs 0.
//  Edge detect: INTR and CLEAR registered once; rise = in & ~in_d. COUNTER sampled the same
//   cycle the rise is seen (registered path, 1-cycle skew matched for COUNTER).
//  Write FSM:
//   W_IDLE: INTR rise -> claim a free slot, write bin 0, idx=1, go W_FILL. If no slot free:
//    drop the frame, OVERFLOW=1, DROP_CNT+1 (sat), go W_DROP. CLEAR rise alone: ignored.
//   W_FILL: INTR rise -> write bin[idx], idx+1. Close when idx reaches NUM_BINS or CLEAR rise:
//    unwritten bins = 0; SHORT_FRAME=1 if idx<NUM_BINS; mark slot full; go W_IDLE.
//    INTR and CLEAR rise same cycle: write the bin first, then close (same cycle).
//   W_DROP: discard INTR rises; CLEAR rise -> W_IDLE.
//   Frame full before CLEAR: later INTR rises up to CLEAR are ignored (W_WAIT, exits on CLEAR).
//  Slot order: frames emitted strictly in close order; write slot toggles per claimed frame.
//  Read FSM:
//   R_IDLE: oldest full slot present -> R_SEND, rd_idx=0; M_VALID rises 1 cycle after the
//    slot is marked full (2 cycles after the closing edge-detect cycle).
//   R_SEND: M_VALID=1, M_DATA=bin[rd_idx], M_LAST=(rd_idx==NUM_BINS-1). On handshake advance;
//    on last handshake free slot, FRAME_CNT+1; next full slot -> continue without a bubble,
//    else R_IDLE. M_DATA/M_LAST held stable while M_VALID & ~M_READY; M_VALID never drops
//    before handshake.
//  Free slot available to writer the cycle after it is freed; slot freed and claimed
//   in the same cycle -> writer sees it busy (one-cycle conservative).
//  CLR_FLAGS and set in same cycle: set wins. DROP_CNT clear and increment same cycle: =1.
//  Reset mid-frame/mid-stream: async, everything discarded, M_VALID drops immediately.
//  Throughput: 1 bin/cycle out; each frame needs NUM_BINS cycles of M_READY.
// TESTING
//  1. NUM_BINS=4; INTR rises with COUNTER=3,7,0,255, then CLEAR -> stream 3,7,0,255,
//     M_LAST on 255, FRAME_CNT=1, SHORT_FRAME=0.
//  2. Two INTR (5,9) then CLEAR -> stream 5,9,0,0; SHORT_FRAME=1; CLR_FLAGS -> 0.
//  3. M_READY=0 held; close 3 frames -> frames 1,2 buffered, 3rd dropped, OVERFLOW=1,
//     DROP_CNT=1; release M_READY -> frames 1,2 out in order, no bubble between them.
//  4. Last INTR rise and CLEAR rise same cycle, COUNTER=42 -> 42 is the final bin of frame.
//  5. 6 INTR rises with NUM_BINS=4 before CLEAR -> only first 4 bins sent; next frame clean.
//  6. Random M_READY toggling; RST_N low mid-stream -> all outputs 0 async; next frame correct.

Source files
------------

// File: rtl/count_frame_packer.sv
// count_frame_packer: packs COUNTER samples into fixed-length frames held in a
// two-slot ping-pong buffer and streams them out over valid/ready.
module count_frame_packer #(
    parameter int NUM_BINS = 16,
    parameter int BIN_W    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INTR,
    input  logic [BIN_W-1:0] COUNTER,
    input  logic             CLEAR,
    input  logic             CLR_FLAGS,
    output logic [BIN_W-1:0] M_DATA,
    output logic             M_VALID,
    output logic             M_LAST,
    input  logic             M_READY,
    output logic [15:0]      FRAME_CNT,
    output logic [7:0]       DROP_CNT,
    output logic             OVERFLOW,
    output logic             SHORT_FRAME
);
    localparam int LW = $clog2(NUM_BINS + 1);
    localparam int IW = $clog2(NUM_BINS);
    localparam logic [LW-1:0] LEN_FULL = LW'(NUM_BINS);
    localparam logic [LW-1:0] IDX_LAST = LW'(NUM_BINS - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_SEND} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q;
    logic              intr_q, clear_q, intr_rise, clear_rise;
    logic [BIN_W-1:0]  mem_q [2][NUM_BINS];
    logic [LW-1:0]     len_q [2];
    logic [1:0]        full_q;
    logic              wr_slot_q, rd_slot_q;
    logic [LW-1:0]     idx_q, idx_d, wr_ptr, rd_idx_q;
    logic              claim, drop, w_write, close, hs, done;

    always_comb begin
        intr_rise  = INTR & ~intr_q;
        clear_rise = CLEAR & ~clear_q;
        claim      = (w_state_q == W_IDLE) && intr_rise && !full_q[wr_slot_q];
        drop       = (w_state_q == W_IDLE) && intr_rise && full_q[wr_slot_q];
        w_write    = claim || ((w_state_q == W_FILL) && intr_rise);
        wr_ptr     = (w_state_q == W_IDLE) ? '0 : idx_q;
        idx_d      = w_write ? wr_ptr + LW'(1) : wr_ptr;
        // A bin arriving with CLEAR is written first, then the frame closes.
        close      = (claim || (w_state_q == W_FILL)) && ((idx_d == LEN_FULL) || clear_rise);
        w_state_d  = close      ? (clear_rise ? W_IDLE : W_WAIT) :
                     claim      ? W_FILL :
                     drop       ? (clear_rise ? W_IDLE : W_DROP) :
                     clear_rise ? W_IDLE : w_state_q;
        hs         = M_VALID & M_READY;
        done       = hs && (rd_idx_q == IDX_LAST);
    end

    // Bins past the written length read back as zero, so slots need no clearing.
    assign M_VALID = (r_state_q == R_SEND);
    assign M_LAST  = M_VALID && (rd_idx_q == IDX_LAST);
    assign M_DATA  = (M_VALID && (rd_idx_q < len_q[rd_slot_q])) ? mem_q[rd_slot_q][rd_idx_q[IW-1:0]] : '0;

    always_ff @(posedge CLK) begin
        if (w_write) mem_q[wr_slot_q][wr_ptr[IW-1:0]] <= COUNTER;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_q      <= 1'b0;
            clear_q     <= 1'b0;
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            idx_q       <= '0;
            rd_idx_q    <= '0;
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            full_q      <= '0;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            FRAME_CNT   <= '0;
            DROP_CNT    <= '0;
            OVERFLOW    <= 1'b0;
            SHORT_FRAME <= 1'b0;
        end else begin
            intr_q      <= INTR;
            clear_q     <= CLEAR;
            w_state_q   <= w_state_d;
            idx_q       <= idx_d;
            wr_slot_q   <= wr_slot_q ^ close;
            if (close) len_q[wr_slot_q] <= idx_d;
            full_q      <= (full_q & ~({1'b0, done} << rd_slot_q)) | ({1'b0, close} << wr_slot_q);
            OVERFLOW    <= drop | (OVERFLOW & ~CLR_FLAGS);
            SHORT_FRAME <= (close && (idx_d != LEN_FULL)) | (SHORT_FRAME & ~CLR_FLAGS);
            DROP_CNT    <= CLR_FLAGS ? {7'd0, drop} : DROP_CNT + {7'd0, drop && (DROP_CNT != 8'hFF)};
            FRAME_CNT   <= FRAME_CNT + {15'd0, done};
            if (r_state_q == R_IDLE) begin
                r_state_q <= full_q[rd_slot_q] ? R_SEND : R_IDLE;
                rd_idx_q  <= '0;
            end else if (hs) begin
                rd_idx_q  <= done ? '0 : rd_idx_q + LW'(1);
                rd_slot_q <= rd_slot_q ^ done;
                r_state_q <= (done && !full_q[~rd_slot_q]) ? R_IDLE : R_SEND;
            end
        end
    end
endmodule
